// File: rtl/fxp_iterative_unit.sv
// rtl/fxp_iterative_unit.sv - multi-cycle signed fixed-point ADD/SUB/MUL/SQRT unit
//
// Purpose:
//   Iterative arithmetic on WIDTH-bit two's-complement Q(WIDTH-FBITS).FBITS
//   operands. One step runs per cycle. MUL walks (WIDTH/MUL_CHUNK)^2 unsigned
//   chunk products and then a finishing cycle. SQRT is a digit-by-digit root
//   that produces one result bit per step. Overflow either saturates or
//   wraps, depending on SATURATE.
//
// Ports:
//   clk        clock
//   reset      asynchronous, active-high reset
//   start      request; sampled only when busy=0 (IDLE or DONE)
//   operation  00 ADD, 01 SUB, 10 MUL, 11 SQRT
//   operand_1  signed fixed-point A
//   operand_2  signed fixed-point B (ignored for SQRT)
//   busy       operation in flight
//   done       one-cycle pulse; result/overflow valid
//   result     fixed-point result, held until the next done
//   overflow   exception flag for the last result, held with result

module fxp_iterative_unit #(
  parameter int WIDTH     = 32,
  parameter int FBITS     = 10,
  parameter int MUL_CHUNK = 16,
  parameter bit SATURATE  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int NCH  = WIDTH / MUL_CHUNK;      // chunks per operand
  localparam int K    = NCH * NCH;              // MUL partial products
  localparam int S    = (WIDTH + FBITS) / 2;    // SQRT steps / root bits
  localparam int RW   = WIDTH + FBITS;          // SQRT radicand width
  localparam int PW   = 2 * WIDTH;              // MUL accumulator width
  localparam int MAXS = (K > S) ? K : S;
  localparam int CW   = $clog2(MAXS + 1);       // step counter width
  localparam int RMW  = S + 4;                  // SQRT remainder width with headroom

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_SQRT = 2'b11;

  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    MUL_FIN = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_next;

  // Latched request
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    step;

  // MUL accumulator and SQRT working registers
  logic [PW-1:0]    acc;
  logic [RW-1:0]    rad;
  logic [RMW-1:0]   rem;
  logic [S-1:0]     root;

  logic accept;
  logic last_step;

  // Saturation or wrap on overflow. neg selects the clamp direction.
  function automatic logic [WIDTH-1:0] clamp(input logic ovf, input logic neg,
                                             input logic [WIDTH-1:0] wrapped);
    if (ovf && SATURATE) begin
      return neg ? NEG_MAX : POS_MAX;
    end
    return wrapped;
  endfunction

  // A new request is taken whenever the unit is not busy, including the DONE
  // cycle, so that back-to-back issue costs no idle cycle.
  assign accept = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    last_step = 1'b1;
    case (op_q)
      OP_MUL:  last_step = (step == CW'(K - 1));
      OP_SQRT: last_step = (step == CW'(S - 1));
      default: last_step = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        if (last_step) state_next = (op_q == OP_MUL) ? MUL_FIN : DONE;
      end
      MUL_FIN: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? EXEC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- ADD/SUB
  // Sign-extended by one bit so that overflow shows up as bit WIDTH
  // disagreeing with bit WIDTH-1.
  logic [WIDTH:0] sum;
  logic           add_ovf;

  always_comb begin
    if (op_q == OP_SUB) begin
      sum = {a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q};
    end else begin
      sum = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
    end
  end

  assign add_ovf = sum[WIDTH] ^ sum[WIDTH-1];

  // ---------------------------------------------------------------- MUL
  // Unsigned magnitudes. The most negative value maps onto 2^(WIDTH-1), which
  // is still correct read as an unsigned number.
  logic [WIDTH-1:0]       mag_a;
  logic [WIDTH-1:0]       mag_b;
  logic [31:0]            ia;
  logic [31:0]            ib;
  logic [MUL_CHUNK-1:0]   ch_a;
  logic [MUL_CHUNK-1:0]   ch_b;
  logic [2*MUL_CHUNK-1:0] pp_raw;
  logic [PW-1:0]          pp;

  assign mag_a = a_q[WIDTH-1] ? (~a_q + WIDTH'(1)) : a_q;
  assign mag_b = b_q[WIDTH-1] ? (~b_q + WIDTH'(1)) : b_q;

  always_comb begin
    ia     = 32'(step) / 32'(NCH);
    ib     = 32'(step) % 32'(NCH);
    ch_a   = MUL_CHUNK'(mag_a >> (ia * 32'(MUL_CHUNK)));
    ch_b   = MUL_CHUNK'(mag_b >> (ib * 32'(MUL_CHUNK)));
    pp_raw = {{MUL_CHUNK{1'b0}}, ch_a} * {{MUL_CHUNK{1'b0}}, ch_b};
    pp     = PW'(pp_raw) << ((ia + ib) * 32'(MUL_CHUNK));
  end

  // The finishing step truncates the magnitude and then restores the sign,
  // which gives rounding toward zero.
  logic [PW-1:0]    prod;
  logic             mul_neg;
  logic             mul_ovf;
  logic [WIDTH-1:0] mul_wrap;

  assign prod     = acc >> FBITS;
  assign mul_neg  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
  assign mul_ovf  = mul_neg ? (prod > PW'(NEG_MAX)) : (prod > PW'(POS_MAX));
  assign mul_wrap = mul_neg ? (~prod[WIDTH-1:0] + WIDTH'(1)) : prod[WIDTH-1:0];

  // ---------------------------------------------------------------- SQRT
  // Each step brings down the next two radicand bits. A 1 goes into the root
  // when the remainder can absorb (root*4 + 1).
  logic [RMW-1:0]   rem_sh;
  logic [RMW-1:0]   trial;
  logic [RMW-1:0]   rem_nx;
  logic [S-1:0]     root_nx;
  logic [WIDTH:0]   root_w;
  logic             sqrt_ovf;

  always_comb begin
    rem_sh = (rem << 2) | RMW'(rad[RW-1:RW-2]);
    trial  = (RMW'(root) << 2) | RMW'(1);
    if (rem_sh >= trial) begin
      rem_nx  = rem_sh - trial;
      root_nx = {root[S-2:0], 1'b1};
    end else begin
      rem_nx  = rem_sh;
      root_nx = {root[S-2:0], 1'b0};
    end
  end

  assign root_w   = (WIDTH + 1)'(root_nx);
  assign sqrt_ovf = root_w > {1'b0, POS_MAX};

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      step     <= '0;
      acc      <= '0;
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      op_q <= operation;
      a_q  <= operand_1;
      b_q  <= operand_2;
      step <= '0;
      acc  <= '0;
      rem  <= '0;
      root <= '0;
      rad  <= RW'(operand_1) << FBITS;
    end else if (state == EXEC) begin
      step <= step + CW'(1);
      case (op_q)
        OP_MUL: begin
          acc <= acc + pp;
        end
        OP_SQRT: begin
          rem  <= rem_nx;
          root <= root_nx;
          rad  <= rad << 2;
          if (last_step) begin
            if (a_q[WIDTH-1]) begin
              // A negative radicand has no real root. The steps still run so
              // that the latency does not depend on the data.
              result   <= '0;
              overflow <= 1'b1;
            end else begin
              result   <= clamp(sqrt_ovf, 1'b0, root_w[WIDTH-1:0]);
              overflow <= sqrt_ovf;
            end
          end
        end
        default: begin
          result   <= clamp(add_ovf, sum[WIDTH], sum[WIDTH-1:0]);
          overflow <= add_ovf;
        end
      endcase
    end else if (state == MUL_FIN) begin
      result   <= clamp(mul_ovf, mul_neg, mul_wrap);
      overflow <= mul_ovf;
    end
  end

endmodule

// File: tb/tb_fxp_iterative_unit.sv
// tb/tb_fxp_iterative_unit.sv - self-checking bench for fxp_iterative_unit

module tb_fxp_iterative_unit;

  logic        clk;
  logic        reset;

  logic        start_a;
  logic [1:0]  op_a;
  logic [31:0] x_a;
  logic [31:0] y_a;
  logic        busy_a;
  logic        done_a;
  logic [31:0] res_a;
  logic        ov_a;

  logic        start_b;
  logic [1:0]  op_b;
  logic [15:0] x_b;
  logic [15:0] y_b;
  logic        busy_b;
  logic        done_b;
  logic [15:0] res_b;
  logic        ov_b;

  int total = 0;
  int bad   = 0;

  fxp_iterative_unit dut_a (
    .clk(clk), .reset(reset), .start(start_a), .operation(op_a),
    .operand_1(x_a), .operand_2(y_a), .busy(busy_a), .done(done_a),
    .result(res_a), .overflow(ov_a)
  );

  fxp_iterative_unit #(.WIDTH(16), .FBITS(4), .MUL_CHUNK(8), .SATURATE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .operation(op_b),
    .operand_1(x_b), .operand_2(y_b), .busy(busy_b), .done(done_b),
    .result(res_b), .overflow(ov_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed arithmetic on plain integers, no iteration structure.
  function automatic logic [32:0] ref_model(input int w, input int f, input bit sat,
                                            input logic [1:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    longint one = 1;
    longint sa, sb, v, m, x, lo, hi, mid, maxv, minv;
    logic   ov;
    sa = longint'(a) & ((one << w) - 1);
    sb = longint'(b) & ((one << w) - 1);
    if (sa >= (one << (w - 1))) sa = sa - (one << w);
    if (sb >= (one << (w - 1))) sb = sb - (one << w);
    maxv = (one << (w - 1)) - 1;
    minv = -(one << (w - 1));
    case (op)
      2'b00: v = sa + sb;
      2'b01: v = sa - sb;
      2'b10: begin
        m = ((sa < 0) ? -sa : sa) * ((sb < 0) ? -sb : sb);
        m = m / (one << f);
        v = ((sa < 0) != (sb < 0)) ? -m : m;
      end
      default: begin
        if (sa < 0) return {1'b1, 32'd0};
        x  = sa * (one << f);
        lo = 0;
        hi = one << ((w + f) / 2 + 1);
        while (lo < hi) begin
          mid = (lo + hi + 1) / 2;
          if (mid * mid <= x) lo = mid;
          else hi = mid - 1;
        end
        v = lo;
      end
    endcase
    ov = (v > maxv) || (v < minv);
    if (ov && sat) v = (v > maxv) ? maxv : minv;
    return {ov, 32'(v & ((one << w) - 1))};
  endfunction

  task automatic drive(input bit sel, input logic s, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (!sel) begin
      start_a = s; op_a = op; x_a = a; y_a = b;
    end else begin
      start_b = s; op_b = op; x_b = a[15:0]; y_b = b[15:0];
    end
  endtask

  function automatic logic sel_done(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  function automatic logic [31:0] sel_res(input bit sel);
    return sel ? {16'd0, res_b} : res_a;
  endfunction

  function automatic logic sel_ov(input bit sel);
    return sel ? ov_b : ov_a;
  endfunction

  // Issues one request and scrambles the inputs straight after the accepting
  // edge, then waits for done, checking the latency and the result.
  task automatic run_op(input bit sel, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_ov, input string tag);
    int lat;
    @(negedge clk);
    drive(sel, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, 2'($urandom), $urandom, $urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!sel_done(sel) && lat < 100);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, 64'(sel_res(sel)), 64'(exp_res));
    check({tag, " overflow"}, 64'(sel_ov(sel)), 64'(exp_ov));
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(sel_done(sel)), 64'd0);
  endtask

  function automatic logic [31:0] pick(input bit sel);
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: begin
        v = $urandom_range(0, 4095);
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      2: begin
        case ($urandom_range(0, 5))
          0: v = 32'd0;
          1: v = 32'd1;
          2: v = 32'hFFFF_FFFF;
          3: v = sel ? 32'h0000_7FFF : 32'h7FFF_FFFF;
          4: v = sel ? 32'hFFFF_8000 : 32'h8000_0000;
          default: v = sel ? 32'h0000_0010 : 32'h0000_0400;
        endcase
      end
      default: v = $urandom_range(0, 255);
    endcase
    if (sel) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic rand_op(input bit sel, input int idx);
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [32:0] exp;
    int          lat;
    op  = 2'($urandom_range(0, 3));
    a   = pick(sel);
    b   = pick(sel);
    exp = sel ? ref_model(16, 4, 1'b0, op, a, b) : ref_model(32, 10, 1'b1, op, a, b);
    lat = (op == 2'b10) ? 5 : (op == 2'b11) ? (sel ? 10 : 21) : 1;
    run_op(sel, op, a, b, lat, exp[31:0], exp[32],
           $sformatf("%s rnd%0d op%0d a=%h b=%h", sel ? "b" : "a", idx, op, a, b));
  endtask

  initial begin
    int          n_done;
    int          first;
    logic [31:0] got;

    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy_a), 64'd0);
    check("reset done", 64'(done_a), 64'd0);
    check("reset result", 64'(res_a), 64'd0);
    check("reset overflow", 64'(ov_a), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases on the default 32-bit saturating unit
    run_op(1'b0, 2'b00, 32'h0000_0C00, 32'h0000_0400, 1, 32'h0000_1000, 1'b0, "add 3+1");
    run_op(1'b0, 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1, 32'h7FFF_FFFF, 1'b1, "add sat");
    run_op(1'b0, 2'b10, 32'd2560, 32'hFFFF_FA00, 5, 32'hFFFF_F100, 1'b0, "mul 2.5*-1.5");
    run_op(1'b0, 2'b10, 32'h7FFF_FFFF, 32'h0000_0800, 5, 32'h7FFF_FFFF, 1'b1, "mul sat");
    run_op(1'b0, 2'b11, 32'h0000_1000, 32'd0, 21, 32'h0000_0800, 1'b0, "sqrt 4");
    run_op(1'b0, 2'b11, 32'h0000_0800, 32'd0, 21, 32'h0000_05A8, 1'b0, "sqrt 2");
    run_op(1'b0, 2'b11, 32'hFFFF_FC00, 32'd0, 21, 32'h0000_0000, 1'b1, "sqrt neg");

    // Directed cases on the 16-bit wrapping unit
    run_op(1'b1, 2'b00, 32'h0000_7FFF, 32'h0000_0001, 1, 32'h0000_8000, 1'b1, "b add wrap");
    run_op(1'b1, 2'b10, 32'h0000_0028, 32'h0000_FFE8, 5, 32'h0000_FFC4, 1'b0, "b mul 2.5*-1.5");
    run_op(1'b1, 2'b11, 32'h0000_0040, 32'd0, 10, 32'h0000_0020, 1'b0, "b sqrt 4");

    // Starts while busy are ignored: one done, with the original product
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 32'd2560, 32'hFFFF_FA00);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    n_done = 0;
    first  = 0;
    got    = 32'd0;
    for (int c = 1; c <= 12; c++) begin
      start_a = (c == 2) || (c == 3);
      if (start_a) begin
        x_a  = $urandom;
        y_a  = $urandom;
        op_a = 2'($urandom);
      end
      @(posedge clk); #1;
      if (done_a) begin
        n_done++;
        if (first == 0) begin
          first = c;
          got   = res_a;
        end
      end
    end
    start_a = 1'b0;
    check("busy start done count", 64'(n_done), 64'd1);
    check("busy start latency", 64'(first), 64'd5);
    check("busy start result", 64'(got), 64'hFFFF_F100);

    // start held through DONE: second ADD accepted in the DONE cycle
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 32'h0000_0C00, 32'h0000_0400);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b first done", 64'(done_a), 64'd1);
    check("b2b first result", 64'(res_a), 64'h0000_1000);
    x_a = 32'h0000_1800;
    y_a = 32'h0000_0400;
    @(posedge clk); #1;
    check("b2b second busy", 64'(busy_a), 64'd1);
    check("b2b gap done", 64'(done_a), 64'd0);
    @(posedge clk); #1;
    start_a = 1'b0;
    check("b2b second done", 64'(done_a), 64'd1);
    check("b2b second result", 64'(res_a), 64'h0000_1C00);
    @(posedge clk); #1;
    check("b2b idle done", 64'(done_a), 64'd0);
    check("b2b idle busy", 64'(busy_a), 64'd0);

    // Reset in the middle of a SQRT aborts it without a done
    run_op(1'b0, 2'b00, 32'h0000_0C00, 32'h0000_0400, 1, 32'h0000_1000, 1'b0, "pre-reset add");
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b11, 32'h0000_1000, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("mid sqrt busy", 64'(busy_a), 64'd1);
    reset = 1'b1;
    #1;
    check("abort busy", 64'(busy_a), 64'd0);
    check("abort done", 64'(done_a), 64'd0);
    check("abort result", 64'(res_a), 64'd0);
    check("abort overflow", 64'(ov_a), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done_a) n_done++;
    end
    check("no done after abort", 64'(n_done), 64'd0);
    run_op(1'b0, 2'b11, 32'h0000_0800, 32'd0, 21, 32'h0000_05A8, 1'b0, "post-reset sqrt");

    // Randomized operations against the reference model
    for (int i = 0; i < 12; i++) rand_op(1'b0, i);
    for (int i = 0; i < 40; i++) rand_op(1'b1, i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
